// File: rtl/clos_port_arbiter.sv
// -----------------------------------------------------------------------------
// clos_port_arbiter
//
// N-to-1 round-robin arbiter with response routing. One instance sits in front
// of each shared output of a Clos stage (or a TCDM bank port). Each cycle it
// picks one requester, forwards that requester's payload downstream, and tracks
// the granted access through a MemLatency-deep pipeline. The response valid is
// then steered back to the requester that issued the access.
//
// Priority comes from one of two sources, selected by ExtPrio:
//   ExtPrio = 0 : an internal fair round-robin pointer
//   ExtPrio = 1 : rr_i, driven by the network's priority source
//
// Ports
//   clk_i     in   1                    clock
//   rst_ni    in   1                    asynchronous active-low reset
//   req_i     in   NumIn                request per requester
//   wen_i     in   NumIn                1 = store, 0 = load
//   wdata_i   in   NumIn*ReqDataWidth   request payload per requester
//   gnt_o     out  NumIn                grant per requester (combinational)
//   vld_o     out  NumIn                response valid per requester
//   rdata_o   out  NumIn*RespDataWidth  rdata_i broadcast to every requester
//   rr_i      in   IdxW                 external priority pointer
//   req_o     out  1                    request to the shared resource
//   wdata_o   out  ReqDataWidth         payload of the selected requester
//   gnt_i     in   1                    grant from the shared resource
//   rdata_i   in   RespDataWidth        response data from the shared resource
// -----------------------------------------------------------------------------
module clos_port_arbiter #(
    parameter int unsigned NumIn         = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned MemLatency    = 1,
    parameter bit          WriteRespOn   = 1'b1,
    parameter bit          ExtPrio       = 1'b0,
    localparam int unsigned IdxW         = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumIn-1:0]                req_i,
    input  logic [NumIn-1:0]                wen_i,
    input  logic [NumIn*ReqDataWidth-1:0]   wdata_i,
    output logic [NumIn-1:0]                gnt_o,
    output logic [NumIn-1:0]                vld_o,
    output logic [NumIn*RespDataWidth-1:0]  rdata_o,
    input  logic [IdxW-1:0]                 rr_i,
    output logic                            req_o,
    output logic [ReqDataWidth-1:0]         wdata_o,
    input  logic                            gnt_i,
    input  logic [RespDataWidth-1:0]        rdata_i
);

    // -------------------------------------------------------------------------
    // Priority pointer and winner selection
    // -------------------------------------------------------------------------
    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] ptr_d;
    logic [IdxW-1:0] ptr_sel;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] cand;
    logic            found;
    logic            hs;
    logic            resp_v;

    // Pointer values outside 0..NumIn-1 (possible when NumIn is not a power of
    // two) fold back into range, so an out-of-range rr_i still selects fairly.
    always_comb begin
        ptr_sel = IdxW'((ExtPrio ? 32'(rr_i) : 32'(ptr_q)) % NumIn);
    end

    // Scan from the pointer upwards, wrapping at NumIn; first request wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned off = 0; off < NumIn; off++) begin
            cand = IdxW'((32'(ptr_sel) + off) % NumIn);
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign req_o = |req_i;
    assign hs    = req_o & gnt_i;

    always_comb begin
        wdata_o = '0;
        if (req_o) begin
            wdata_o = wdata_i[win_idx*ReqDataWidth +: ReqDataWidth];
        end
    end

    always_comb begin
        gnt_o = '0;
        if (req_o) begin
            gnt_o[win_idx] = gnt_i;
        end
    end

    // The pointer moves just past the winner, but only on an accepted
    // handshake; a stalled request keeps its priority position.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = IdxW'((32'(win_idx) + 1) % NumIn);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its inputs from before the edge, regardless of block order.
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Response pipeline: one {v, idx} entry per cycle of memory latency
    // -------------------------------------------------------------------------
    logic [MemLatency-1:0] v_q;
    logic [IdxW-1:0]       idx_q [MemLatency];

    // Stores only produce a response when WriteRespOn is set.
    assign resp_v = hs & (WriteRespOn | ~wen_i[win_idx]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
        end else begin
            v_q[0] <= resp_v;
            for (int unsigned k = 1; k < MemLatency; k++) begin
                v_q[k] <= v_q[k-1];
            end
        end
    end

    // NOTE: the idx entries carry no reset; they are only observed while the
    // matching v bit is set, and v is cleared by reset.
    always_ff @(posedge clk_i) begin
        idx_q[0] <= win_idx;
        for (int unsigned k = 1; k < MemLatency; k++) begin
            idx_q[k] <= idx_q[k-1];
        end
    end

    always_comb begin
        vld_o = '0;
        vld_o[idx_q[MemLatency-1]] = v_q[MemLatency-1];
    end

    // Response data is shared by all requesters; vld_o qualifies it.
    assign rdata_o = {NumIn{rdata_i}};

endmodule
